// File: rtl/rv_mem_decode.sv
// Unified byte-addressed little-endian RAM with a registered read port and a combinational RV32 field decoder.
// Read data appears one edge after the address; reset clears only the read register, never the RAM.
package rv_mem_decode_pkg;
   typedef enum logic [2:0] {
      UNKNOWN = 3'd0,
      LOAD    = 3'd1,
      OP_IMM  = 3'd2,
      OP      = 3'd3,
      STORE   = 3'd4
   } opcode_t;
endpackage

module rv_mem_decode
   import rv_mem_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ILEN      = 32,
   parameter int MEM_BYTES = 3072,
   parameter     INIT_FILE = ""
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [1:0]      mem_wwidth,
   input  logic            mem_wenable,
   input  logic [XLEN-1:0] mem_wdata,
   output logic [XLEN-1:0] mem_rdata,
   input  logic [ILEN-1:0] instr,
   output opcode_t         opcode,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] i_imm,
   output logic [XLEN-1:0] s_imm
);

   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]      mem_q [MEM_BYTES];
   logic [XLEN-1:0] rdata_d, rdata_q;
   logic [XLEN:0]   baddr [4];
   logic [AW-1:0]   bidx  [4];
   logic [3:0]      in_range;
   logic [3:0]      wmask;
   logic [3:0]      wbe;

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) begin
         mem_q[i] = 8'h00;
      end
   end

   always_comb begin
      case (mem_wwidth)
         2'd0:    wmask = 4'b0001;
         2'd1:    wmask = 4'b0011;
         2'd2:    wmask = 4'b1111;
         default: wmask = 4'b0000;
      endcase
   end

   // Byte addresses are formed one bit wider than XLEN so a top-of-space access never wraps to 0.
   always_comb begin
      rdata_d = '0;
      wbe     = '0;
      for (int k = 0; k < 4; k++) begin
         baddr[k]    = {1'b0, mem_addr} + (XLEN+1)'(k);
         bidx[k]     = baddr[k][AW-1:0];
         in_range[k] = (baddr[k] < (XLEN+1)'(MEM_BYTES));
         if (in_range[k]) begin
            rdata_d[8*k +: 8] = mem_q[bidx[k]];
         end
         wbe[k] = in_range[k] & wmask[k] & mem_wenable & reset;
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < 4; k++) begin
         if (wbe[k]) begin
            mem_q[bidx[k]] <= mem_wdata[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign mem_rdata = rdata_q;

   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign i_imm  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign s_imm  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

   always_comb begin
      case (instr[6:0])
         7'b0000011: opcode = LOAD;
         7'b0010011: opcode = OP_IMM;
         7'b0110011: opcode = OP;
         7'b0100011: opcode = STORE;
         default:    opcode = UNKNOWN;
      endcase
   end

endmodule

// File: tb/tb_rv_mem_decode.sv
// Directed bench for rv_mem_decode: RAM read/write/reset behaviour and instruction field decode.
module tb_rv_mem_decode;
   import rv_mem_decode_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [1:0]  mem_wwidth = 2'd3;
   logic        mem_wenable = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic [31:0] instr = '0;
   opcode_t     opcode;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] i_imm, s_imm;

   int checks = 0;
   int errors = 0;

   rv_mem_decode dut (
      .clock(clock), .reset(reset),
      .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wenable(mem_wenable),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .instr(instr), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
      .funct3(funct3), .funct7(funct7), .i_imm(i_imm), .s_imm(s_imm)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
      mem_addr    = a;
      mem_wwidth  = w;
      mem_wdata   = d;
      mem_wenable = 1'b1;
      tick();
      mem_wenable = 1'b0;
      mem_wwidth  = 2'd3;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mem_addr = a;
      tick();
      check(tag, mem_rdata, exp);
   endtask

   initial begin
      tick();
      tick();
      check("reset_rdata", mem_rdata, 32'h0);
      reset = 1'b1;

      wr(32'h100, 2'd2, 32'hDEADBEEF);
      rd_chk("pre_reset_read", 32'h100, 32'hDEADBEEF);
      #2 reset = 1'b0;
      #1 check("async_reset_clear", mem_rdata, 32'h0);
      tick();
      check("reset_hold_no_write", mem_rdata, 32'h0);
      reset = 1'b1;
      rd_chk("ram_retained", 32'h100, 32'hDEADBEEF);

      wr(32'h10, 2'd2, 32'h11223344);
      wr(32'h14, 2'd2, 32'h00000000);
      rd_chk("word_rw", 32'h10, 32'h11223344);
      rd_chk("unaligned_read", 32'h11, 32'h00112233);

      wr(32'h20, 2'd2, 32'hFFFFFFFF);
      wr(32'h21, 2'd0, 32'h777777AB);
      wr(32'h22, 2'd1, 32'h55551234);
      rd_chk("subword_merge", 32'h20, 32'h1234ABFF);
      wr(32'h20, 2'd3, 32'h00000000);
      rd_chk("nowrite_width3", 32'h20, 32'h1234ABFF);

      wr(32'hBFE, 2'd2, 32'hCAFEBABE);
      rd_chk("top_clip_read", 32'hBFE, 32'h0000BABE);
      rd_chk("top_last_byte", 32'hBFF, 32'h000000BA);
      rd_chk("no_wrap_low", 32'h0, 32'h00000000);
      rd_chk("past_end", 32'hC00, 32'h00000000);

      mem_addr    = 32'h10;
      mem_wdata   = 32'h55667788;
      mem_wwidth  = 2'd2;
      mem_wenable = 1'b1;
      tick();
      check("collision_old", mem_rdata, 32'h11223344);
      mem_wenable = 1'b0;
      mem_wwidth  = 2'd3;
      tick();
      check("collision_new", mem_rdata, 32'h55667788);

      instr = 32'hFF010113;
      #1;
      check("d1_opcode", 32'(opcode), 32'(OP_IMM));
      check("d1_rd", 32'(rd), 32'd2);
      check("d1_rs1", 32'(rs1), 32'd2);
      check("d1_funct3", 32'(funct3), 32'd0);
      check("d1_i_imm", i_imm, 32'hFFFFFFF0);

      instr = 32'h00812283;
      #1;
      check("d2_opcode", 32'(opcode), 32'(LOAD));
      check("d2_rd", 32'(rd), 32'd5);
      check("d2_rs1", 32'(rs1), 32'd2);
      check("d2_funct3", 32'(funct3), 32'd2);
      check("d2_i_imm", i_imm, 32'd8);

      instr = 32'h00112623;
      #1;
      check("d3_opcode", 32'(opcode), 32'(STORE));
      check("d3_rs1", 32'(rs1), 32'd2);
      check("d3_rs2", 32'(rs2), 32'd1);
      check("d3_funct3", 32'(funct3), 32'd2);
      check("d3_s_imm", s_imm, 32'd12);

      instr = 32'h402081B3;
      #1;
      check("d4_opcode", 32'(opcode), 32'(OP));
      check("d4_rd", 32'(rd), 32'd3);
      check("d4_rs1", 32'(rs1), 32'd1);
      check("d4_rs2", 32'(rs2), 32'd2);
      check("d4_funct7", 32'(funct7), 32'h20);

      instr = 32'hFE112E23;
      #1;
      check("d5_s_imm_neg", s_imm, 32'hFFFFFFFC);

      instr = 32'h0000006F;
      #1;
      check("d6_opcode", 32'(opcode), 32'(UNKNOWN));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
